adc_readout_scheduler: RTL

- Sequences readout of the delta-sigma comparator ADC.
- On an external trigger or an internal periodic tick, it waits for the next decimated CIC sample strobe and snapshots channel A, channel B and the A-B difference together.
- It then serialises the enabled channels in a fixed order onto a single shared serial pin, replacing the three per-channel serialisers.
- Each channel word is tagged with a 2-bit channel id so one pin carries all three results.

---
 rtl/adc_readout_scheduler.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_readout_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : adc_readout_scheduler
//  Purpose  : Readout sequencer for the delta-sigma comparator ADC.
//             A trigger (external rising edge or internal periodic tick)
//             arms the block; the next decimated sample strobe snapshots
//             channels A, B and A-B coherently.  The enabled channels are
//             then shifted out, in the order A, B, A-B, on one shared serial
//             pin.  Each word is a 2-bit channel id followed by the data,
//             MSB first.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             trig_in, auto_en    - external trigger level, periodic enable
//             ch_mask             - channel enables {A-B, B, A}
//             clr_ovr             - clears the sticky overrun flag
//             sample_strobe       - new CIC sample available on data_*
//             data_a/b/ab         - filtered channel words
//             ser_out, ser_valid  - serial data, first-bit-of-word marker
//             busy, frame_done    - activity level, end-of-frame pulse
//             overrun             - trigger seen while a frame was pending
//  Revision : 1.0 - initial release
// ============================================================================
module adc_readout_scheduler #(
    parameter int WIDTH  = 13,
    parameter int PERIOD = 4096,
    parameter int GAP    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic             auto_en,
    input  logic [2:0]       ch_mask,
    input  logic             clr_ovr,
    input  logic             sample_strobe,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_ab,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    localparam int c_CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int c_BIT_W = $clog2(WIDTH + 2);
    localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PERIOD - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // Returns {found, id} of the lowest enabled channel whose id is above
    // cur.  Channel ids are A=1, B=2, A-B=3, so cur=0 yields the first one.
    function automatic logic [2:0] f_next_chan(input logic [2:0] mask,
                                               input logic [1:0] cur);
        if ((cur < 2'd1) && mask[0]) return 3'b101;
        if ((cur < 2'd2) && mask[1]) return 3'b110;
        if ((cur < 2'd3) && mask[2]) return 3'b111;
        return 3'b000;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_trig_q;
    logic [WIDTH-1:0]   r_snap_a;
    logic [WIDTH-1:0]   r_snap_b;
    logic [WIDTH-1:0]   r_snap_ab;
    logic [2:0]         r_mask;
    logic [1:0]         r_chan;
    logic [c_BIT_W-1:0] r_bit;
    logic [c_GAP_W-1:0] r_gap;
    logic               r_ser_out;
    logic               r_ser_valid;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_overrun;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic               w_auto_tick;
    logic               w_evt;
    logic               w_ovr_set;
    logic [2:0]         w_first;
    logic [2:0]         w_follow;
    state_t             w_state_nxt;
    logic [1:0]         w_chan_nxt;
    logic [c_BIT_W-1:0] w_bit_nxt;
    logic [c_GAP_W-1:0] w_gap_nxt;
    logic [WIDTH-1:0]   w_snap_a_nxt;
    logic [WIDTH-1:0]   w_snap_b_nxt;
    logic [WIDTH-1:0]   w_snap_ab_nxt;
    logic [2:0]         w_mask_nxt;
    logic               w_done;
    logic [WIDTH-1:0]   w_sel;
    logic [WIDTH+1:0]   w_word;
    logic [WIDTH+1:0]   w_word_shifted;

    assign w_auto_tick = auto_en && (r_cnt == c_CNT_LAST);
    // A coincident external edge and periodic tick collapse into one event.
    assign w_evt       = (trig_in & ~r_trig_q) | w_auto_tick;
    assign w_ovr_set   = w_evt && (r_state != S_IDLE);
    assign w_first     = f_next_chan(ch_mask, 2'd0);
    assign w_follow    = f_next_chan(r_mask, r_chan);

    always_comb begin
        w_state_nxt   = r_state;
        w_chan_nxt    = r_chan;
        w_bit_nxt     = r_bit;
        w_gap_nxt     = r_gap;
        w_snap_a_nxt  = r_snap_a;
        w_snap_b_nxt  = r_snap_b;
        w_snap_ab_nxt = r_snap_ab;
        w_mask_nxt    = r_mask;
        w_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_evt && (ch_mask != 3'b000)) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sample_strobe) begin
                    w_snap_a_nxt  = data_a;
                    w_snap_b_nxt  = data_b;
                    w_snap_ab_nxt = data_ab;
                    w_mask_nxt    = ch_mask;
                    if (w_first[2]) begin
                        w_state_nxt = S_SHIFT;
                        w_chan_nxt  = w_first[1:0];
                        w_bit_nxt   = '0;
                    end else begin
                        // Mask was cleared while waiting: nothing to send.
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_SHIFT: begin
                if (r_bit == c_BIT_LAST) begin
                    if (w_follow[2]) begin
                        w_chan_nxt  = w_follow[1:0];
                        w_bit_nxt   = '0;
                        w_gap_nxt   = '0;
                        w_state_nxt = (GAP == 0) ? S_SHIFT : S_GAP;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end else begin
                    w_bit_nxt = r_bit + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = S_SHIFT;
                    w_bit_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The serial outputs are registered from next-state values so the id
    // MSB appears in the cycle right after the capturing strobe edge.
    always_comb begin
        case (w_chan_nxt)
            2'd1:    w_sel = w_snap_a_nxt;
            2'd2:    w_sel = w_snap_b_nxt;
            default: w_sel = w_snap_ab_nxt;
        endcase
        w_word         = {w_chan_nxt, w_sel};
        w_word_shifted = w_word << w_bit_nxt;
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!auto_en || w_auto_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_trig_q  <= 1'b0;
            r_snap_a  <= '0;
            r_snap_b  <= '0;
            r_snap_ab <= '0;
            r_mask    <= 3'b000;
            r_chan    <= 2'd0;
            r_bit     <= '0;
            r_gap     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_trig_q  <= trig_in;
            r_snap_a  <= w_snap_a_nxt;
            r_snap_b  <= w_snap_b_nxt;
            r_snap_ab <= w_snap_ab_nxt;
            r_mask    <= w_mask_nxt;
            r_chan    <= w_chan_nxt;
            r_bit     <= w_bit_nxt;
            r_gap     <= w_gap_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ser_out    <= 1'b0;
            r_ser_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_ser_out    <= (w_state_nxt == S_SHIFT) && w_word_shifted[WIDTH+1];
            r_ser_valid  <= (w_state_nxt == S_SHIFT) && (w_bit_nxt == '0);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_done;
            // A new overrun takes priority over a simultaneous clear.
            r_overrun    <= w_ovr_set | (r_overrun & ~clr_ovr);
        end
    end

    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
